// File: rtl/hc153_scan_ctrl.sv
// hc153_scan_ctrl: round-robin sequencer and arbiter for one shared HC153 dual 4:1 mux.
// Optional macro HC153_SCAN_AUTO_EN: when idle with no request, auto-scan channel (last+1) mod 4.
module hc153_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned CW         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       y1,
    input  logic       y2,
    output logic       s1,
    output logic       s2,
    output logic       e1n,
    output logic       e2n,
    output logic [3:0] gnt,
    output logic [1:0] chan,
    output logic       d1,
    output logic       d2,
    output logic       vld,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_chan, w_chan_nxt;
    logic [1:0]    r_last, w_last_nxt;
    logic          r_d1, w_d1_nxt;
    logic          r_d2, w_d2_nxt;
    logic          r_auto, w_auto_nxt;

    logic [1:0]    w_pick;
    logic [1:0]    w_idx;
    logic          w_found;

    // Scan from the channel after the last winner; w_pick defaults to that channel.
    always_comb begin
        w_pick  = r_last + 2'd1;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_last + 2'd1 + i[1:0];
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_last_nxt  = r_last;
        w_d1_nxt    = r_d1;
        w_d2_nxt    = r_d2;
        w_auto_nxt  = r_auto;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_chan_nxt  = w_pick;
                    w_cnt_nxt   = CW'(SETTLE_CYC - 1);
                    w_auto_nxt  = 1'b0;
                    w_state_nxt = ST_SETUP;
                end
`ifdef HC153_SCAN_AUTO_EN
                else begin
                    w_chan_nxt  = w_pick;
                    w_cnt_nxt   = CW'(SETTLE_CYC - 1);
                    w_auto_nxt  = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
`endif
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = CW'(HOLD_CYC - 1);
                    w_state_nxt = ST_ENABLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_ENABLE: begin
                if (r_cnt == '0) begin
                    w_d1_nxt    = y1;
                    w_d2_nxt    = y2;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DONE: begin
                w_last_nxt  = r_chan;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_chan  <= '0;
            r_last  <= 2'd3;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
            r_auto  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
            r_last  <= w_last_nxt;
            r_d1    <= w_d1_nxt;
            r_d2    <= w_d2_nxt;
            r_auto  <= w_auto_nxt;
        end
    end

    // Selects follow chan, which only moves on the IDLE arbitration edge while enables are high.
    assign s1   = r_chan[0];
    assign s2   = r_chan[1];
    assign chan = r_chan;
    assign e1n  = (r_state != ST_ENABLE);
    assign e2n  = (r_state != ST_ENABLE);
    assign d1   = r_d1;
    assign d2   = r_d2;
    assign vld  = (r_state == ST_DONE);
    assign busy = (r_state != ST_IDLE);
    assign gnt  = (vld && !r_auto) ? (4'b0001 << r_chan) : '0;

endmodule
